image_buffer: RTL and testbench

Ping-pong input-image buffer between the pixel decimators and the feedforward network. It captures 256-pixel (16×16) uint8 frames streamed from the decimator into one of two banks. It presents a completed frame to the network as a random-access, combinational-read memory indexed by the network's `cycle` address, with the bias input at address 0. Capture of the next frame continues into the other bank while the network runs.

---
 rtl/image_buffer_pkg.sv | 24 ++
 rtl/image_buffer_px_bank.sv | 31 +++
 rtl/image_buffer.sv | 169 ++++++++++++++++
 tb/tb_image_buffer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/image_buffer_pkg.sv
// Shared definitions for the input-image buffer.
// Provides the pixel/address widths, the input-layer size, the bias pixel
// value, the per-bank ownership state and the write FSM state type.
package image_buffer_pkg;

  localparam int UINT_8          = 8;
  localparam int ADR_LEN         = 9;
  localparam int INPUT_LAYER_LEN = 257;
  localparam int NUM_PX          = 256;
  localparam logic [7:0] BIAS_PX = 8'hFF;

  typedef enum logic [1:0] {
    FREE,
    FILLING,
    FULL,
    READING
  } bankstate_t;

  typedef enum logic {
    W_IDLE,
    W_FILL
  } wstate_t;

endpackage

// File: rtl/image_buffer_px_bank.sv
// px_bank: one frame of pixel storage.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write pixel index
//   wdata - pixel to store
//   raddr - read pixel index
//   rdata - pixel at raddr (asynchronous read)
// Contents are not reset.
module px_bank #(
  parameter int PX_W   = image_buffer_pkg::UINT_8,
  parameter int NUM_PX = image_buffer_pkg::NUM_PX,
  parameter int AW     = $clog2(NUM_PX)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [PX_W-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [PX_W-1:0] rdata
);

  logic [PX_W-1:0] mem [NUM_PX];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/image_buffer.sv
// image_buffer: ping-pong frame buffer between the pixel decimators and the
// feedforward network.
// Ports:
//   clk, reset           - clock, asynchronous active-low reset
//   px_valid/px_sof/px_data - decimator pixel stream (no backpressure)
//   rd_addr/rd_data      - network read port; addr 0 is the bias pixel,
//                          1..NUM_PX map to pixels 0..NUM_PX-1, above reads 0
//   frame_valid          - read bank holds a complete frame owned by the network
//   frame_done           - network releases the read bank
//   short_frame          - pulse: partial frame aborted by a new sof
//   drop_count           - saturating count of frames dropped for lack of a bank
module image_buffer
  import image_buffer_pkg::*;
#(
  parameter int PX_W   = UINT_8,
  parameter int NUM_PX = image_buffer_pkg::NUM_PX,
  parameter int ADR_W  = ADR_LEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             px_valid,
  input  logic             px_sof,
  input  logic [PX_W-1:0]  px_data,
  input  logic [ADR_W-1:0] rd_addr,
  output logic [PX_W-1:0]  rd_data,
  output logic             frame_valid,
  input  logic             frame_done,
  output logic             short_frame,
  output logic [7:0]       drop_count
);

  localparam int AW = $clog2(NUM_PX);

  bankstate_t      bank_st [2];
  bankstate_t      bank_nxt [2];
  wstate_t         wstate, wstate_nxt;
  logic            wsel, wsel_nxt;
  logic            rsel, rsel_nxt;
  logic [AW-1:0]   count, count_nxt;
  logic            fv_nxt, short_nxt;
  logic [7:0]      drop_nxt;
  logic [1:0]      we;
  logic [AW-1:0]   waddr;
  logic [AW-1:0]   raddr;
  logic [PX_W-1:0] rdata0, rdata1;
  logic            have_free, free_sel;

  assign have_free = (bank_st[0] == FREE) || (bank_st[1] == FREE);
  assign free_sel  = (bank_st[0] == FREE) ? 1'b0 : 1'b1;

  // Write and read sides always touch different banks (FREE/FILLING vs
  // FULL/READING), so both may update bank_nxt in the same cycle.
  always_comb begin
    bank_nxt   = bank_st;
    wstate_nxt = wstate;
    wsel_nxt   = wsel;
    rsel_nxt   = rsel;
    count_nxt  = count;
    fv_nxt     = frame_valid;
    short_nxt  = 1'b0;
    drop_nxt   = drop_count;
    we         = '0;
    waddr      = count;

    unique case (wstate)
      W_IDLE: begin
        if (px_valid && px_sof) begin
          if (have_free) begin
            wsel_nxt           = free_sel;
            bank_nxt[free_sel] = FILLING;
            we[free_sel]       = 1'b1;
            waddr              = '0;
            count_nxt          = AW'(1);
            wstate_nxt         = W_FILL;
          end else if (drop_count != 8'hFF) begin
            drop_nxt = drop_count + 8'd1;
          end
        end
      end
      W_FILL: begin
        if (px_valid) begin
          we[wsel] = 1'b1;
          if (px_sof) begin
            short_nxt = 1'b1;
            waddr     = '0;
            count_nxt = AW'(1);
          end else if (count == AW'(NUM_PX - 1)) begin
            bank_nxt[wsel] = FULL;
            count_nxt      = '0;
            wstate_nxt     = W_IDLE;
          end else begin
            count_nxt = count + AW'(1);
          end
        end
      end
      default: wstate_nxt = W_IDLE;
    endcase

    // Promotion only looks at registered state, so a bank released this
    // cycle forces one low cycle of frame_valid before the next hand-off.
    if (frame_valid) begin
      if (frame_done) begin
        bank_nxt[rsel] = FREE;
        fv_nxt         = 1'b0;
      end
    end else if (bank_st[0] == FULL) begin
      bank_nxt[0] = READING;
      rsel_nxt    = 1'b0;
      fv_nxt      = 1'b1;
    end else if (bank_st[1] == FULL) begin
      bank_nxt[1] = READING;
      rsel_nxt    = 1'b1;
      fv_nxt      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_st[0]  <= FREE;
      bank_st[1]  <= FREE;
      wstate      <= W_IDLE;
      wsel        <= 1'b0;
      rsel        <= 1'b0;
      count       <= '0;
      frame_valid <= 1'b0;
      short_frame <= 1'b0;
      drop_count  <= '0;
    end else begin
      bank_st     <= bank_nxt;
      wstate      <= wstate_nxt;
      wsel        <= wsel_nxt;
      rsel        <= rsel_nxt;
      count       <= count_nxt;
      frame_valid <= fv_nxt;
      short_frame <= short_nxt;
      drop_count  <= drop_nxt;
    end
  end

  assign raddr = AW'(rd_addr - ADR_W'(1));

  px_bank #(.PX_W(PX_W), .NUM_PX(NUM_PX), .AW(AW)) u_bank0 (
    .clk   (clk),
    .we    (we[0]),
    .waddr (waddr),
    .wdata (px_data),
    .raddr (raddr),
    .rdata (rdata0)
  );

  px_bank #(.PX_W(PX_W), .NUM_PX(NUM_PX), .AW(AW)) u_bank1 (
    .clk   (clk),
    .we    (we[1]),
    .waddr (waddr),
    .wdata (px_data),
    .raddr (raddr),
    .rdata (rdata1)
  );

  always_comb begin
    rd_data = '0;
    if (rd_addr == '0) begin
      rd_data = PX_W'(BIAS_PX);
    end else if (rd_addr <= ADR_W'(NUM_PX)) begin
      rd_data = rsel ? rdata1 : rdata0;
    end
  end

endmodule

// File: tb/tb_image_buffer.sv
`timescale 1ns/100ps
module tb_image_buffer;

  typedef logic [255:0][7:0] frame_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       px_valid = 1'b0;
  logic       px_sof = 1'b0;
  logic [7:0] px_data = '0;
  logic [8:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       frame_valid;
  logic       frame_done = 1'b0;
  logic       short_frame;
  logic [7:0] drop_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  image_buffer #(.PX_W(8), .NUM_PX(256), .ADR_W(9)) dut (
    .clk         (clk),
    .reset       (reset),
    .px_valid    (px_valid),
    .px_sof      (px_sof),
    .px_data     (px_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_valid (frame_valid),
    .frame_done  (frame_done),
    .short_frame (short_frame),
    .drop_count  (drop_count)
  );

  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: frames being filled, completed frames waiting in
  // order, and the one frame the network holds. Two frames of storage total.
  frame_t     m_cur = '0;
  frame_t     m_read = '0;
  frame_t     m_pend[$];
  bit         m_fill_on = 1'b0;
  int         m_idx = 0;
  bit         m_valid = 1'b0;
  bit         m_short = 1'b0;
  int         m_drops = 0;
  int         occ;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_fill_on = 1'b0;
      m_idx     = 0;
      m_pend.delete();
      m_valid   = 1'b0;
      m_short   = 1'b0;
      m_drops   = 0;
    end else begin
      occ = int'(m_fill_on) + m_pend.size() + int'(m_valid);
      m_short = 1'b0;
      if (m_valid) begin
        if (frame_done) m_valid = 1'b0;
      end else if (m_pend.size() > 0) begin
        m_read  = m_pend.pop_front();
        m_valid = 1'b1;
      end
      if (px_valid) begin
        if (!m_fill_on) begin
          if (px_sof) begin
            if (occ < 2) begin
              m_fill_on = 1'b1;
              m_cur[0]  = px_data;
              m_idx     = 1;
            end else if (m_drops < 255) begin
              m_drops++;
            end
          end
        end else if (px_sof) begin
          m_short  = 1'b1;
          m_cur[0] = px_data;
          m_idx    = 1;
        end else begin
          m_cur[m_idx] = px_data;
          m_idx++;
          if (m_idx == 256) begin
            m_pend.push_back(m_cur);
            m_fill_on = 1'b0;
          end
        end
      end
    end
  end

  function automatic logic [7:0] exp_rd(input logic [8:0] a);
    if (a == 9'd0) return 8'hFF;
    if (a <= 9'd256) return m_read[int'(a) - 1];
    return 8'h00;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_frame_valid", 32'(frame_valid), 32'd0);
      chk("rst_short_frame", 32'(short_frame), 32'd0);
      chk("rst_drop_count", 32'(drop_count), 32'd0);
    end else begin
      chk("frame_valid", 32'(frame_valid), 32'(m_valid));
      chk("short_frame", 32'(short_frame), 32'(m_short));
      chk("drop_count", 32'(drop_count), 32'(m_drops));
      if (m_valid) chk("rd_data", 32'(rd_data), 32'(exp_rd(rd_addr)));
    end
  end

  logic [8:0] addr_tab [10] = '{9'd0, 9'd1, 9'd2, 9'd5, 9'd100,
                                9'd255, 9'd256, 9'd257, 9'd300, 9'd511};

  function automatic logic [7:0] pix(input int kind, input int i);
    case (kind)
      0:       return 8'(i);
      1:       return 8'(255 - i);
      2:       return 8'(i) ^ 8'h5A;
      3:       return 8'(i * 3);
      4:       return 8'(i + 7);
      default: return 8'(i) ^ 8'hA5;
    endcase
  endfunction

  task automatic step(input bit v, input bit s, input logic [7:0] d, input bit done);
    px_valid   = v;
    px_sof     = s;
    px_data    = d;
    frame_done = done;
    rd_addr    = addr_tab[cyc % 10];
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_frame(input int kind, input bit done_last);
    for (int i = 0; i < 256; i++)
      step(1'b1, i == 0, pix(kind, i), done_last && (i == 255));
  endtask

  task automatic rdchk(input string nm, input logic [8:0] a, input logic [7:0] e);
    rd_addr = a;
    #1;
    chk(nm, 32'(rd_data), 32'(e));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_fv", 32'(frame_valid), 32'd0);
    chk("reset_drop", 32'(drop_count), 32'd0);
    chk("reset_short", 32'(short_frame), 32'd0);
    reset = 1'b1;
    idle(2);

    // Frame A: values i
    send_frame(0, 1'b0);
    chk("A_fv_not_yet", 32'(frame_valid), 32'd0);
    idle(1);
    chk("A_fv_rise", 32'(frame_valid), 32'd1);
    rdchk("A_bias", 9'd0, 8'hFF);
    rdchk("A_addr1", 9'd1, 8'h00);
    rdchk("A_addr256", 9'd256, 8'hFF);
    rdchk("A_addr300", 9'd300, 8'h00);
    idle(3);

    // Frame B captured while A is held
    send_frame(1, 1'b0);
    idle(2);
    chk("B_held_fv", 32'(frame_valid), 32'd1);
    rdchk("B_still_A", 9'd5, 8'h04);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("B_gap", 32'(frame_valid), 32'd0);
    idle(1);
    chk("B_fv", 32'(frame_valid), 32'd1);
    rdchk("B_addr5", 9'd5, 8'hFB);

    // Frame C fills the free bank, then drops until saturation
    send_frame(2, 1'b0);
    step(1'b1, 1'b1, 8'h11, 1'b0);
    chk("drop_one", 32'(drop_count), 32'd1);
    for (int i = 0; i < 299; i++) step(1'b1, 1'b1, 8'h22, 1'b0);
    chk("drop_sat", 32'(drop_count), 32'd255);
    idle(1);

    // Release B, C is promoted after the gap; then release C
    step(1'b0, 1'b0, 8'h00, 1'b1);
    idle(1);
    rdchk("C_addr1", 9'd1, 8'h5A);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    idle(2);
    step(1'b0, 1'b0, 8'h00, 1'b1); // ignored: nothing held

    // Short frame: 100 pixels then restart with a full frame
    for (int i = 0; i < 100; i++) step(1'b1, i == 0, 8'hEE, 1'b0);
    step(1'b1, 1'b1, pix(3, 0), 1'b0);
    chk("short_pulse", 32'(short_frame), 32'd1);
    for (int i = 1; i < 256; i++) step(1'b1, 1'b0, pix(3, i), 1'b0);
    chk("short_gone", 32'(short_frame), 32'd0);
    idle(1);
    chk("E_fv", 32'(frame_valid), 32'd1);
    rdchk("E_addr101", 9'd101, 8'h2C);
    rdchk("E_addr50", 9'd50, 8'h93);
    idle(2);

    // frame_done coincides with the pixel-255 write
    send_frame(4, 1'b1);
    chk("F_gap", 32'(frame_valid), 32'd0);
    idle(1);
    chk("F_fv", 32'(frame_valid), 32'd1);
    rdchk("F_addr1", 9'd1, 8'h07);

    // Reset mid-fill while a frame is held
    for (int i = 0; i < 50; i++) step(1'b1, i == 0, pix(0, i), 1'b0);
    reset = 1'b0;
    #1;
    chk("async_fv", 32'(frame_valid), 32'd0);
    chk("async_drop", 32'(drop_count), 32'd0);
    idle(2);
    reset = 1'b1;
    idle(1);
    send_frame(5, 1'b0);
    idle(1);
    chk("H_fv", 32'(frame_valid), 32'd1);
    rdchk("H_addr2", 9'd2, 8'hA4);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
